// File: rtl/excitation_source_if.sv
// Sample-tick, frame-parameter and filter start/done signals of the excitation source.
// The slave side is the excitation source; the master side is its controller plus the filter.
interface excitation_source_if;
    logic        sample_tick;
    logic [7:0]  period;
    logic [7:0]  amplitude;
    logic        param_load;
    logic [15:0] sig_out;
    logic        filt_start;
    logic        filt_done;
    logic        busy;
    logic        overrun;

    modport master (
        output sample_tick, period, amplitude, param_load, filt_done,
        input  sig_out, filt_start, busy, overrun
    );

    modport slave (
        input  sample_tick, period, amplitude, param_load, filt_done,
        output sig_out, filt_start, busy, overrun
    );
endinterface

// File: rtl/excitation_source.sv
// Pulse-train / LFSR-noise excitation generator feeding the all-pole filter over start/done.
// Optional EXCITATION_AMP_SMOOTH_EN: the applied amplitude slews 1 LSB per accepted sample.
module excitation_source #(
    parameter logic [16:0] LFSR_SEED = 17'h00001,
    parameter int unsigned HOLDOFF   = 2
) (
    input logic                clk,
    input logic                rst_an,
    excitation_source_if.slave bus
);
    localparam int unsigned HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    per_r, amp_r, pcnt, pcnt_nxt, amp_use;
    logic [16:0]   lfsr;
    logic [15:0]   sig_r, sample_nxt, mag;
    logic          start_r, start_nxt, overrun_r;
    logic [HW-1:0] hcnt;
    logic          accept, tick_drop;

    assign accept    = bus.sample_tick && (state == IDLE);
    assign tick_drop = bus.sample_tick && (state != IDLE);

`ifdef EXCITATION_AMP_SMOOTH_EN
    logic [7:0] amp_cur;
    assign amp_use = amp_cur;

    // The step is taken after the sample is formed with the current amp_cur.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            amp_cur <= 8'd0;
        end else if (accept) begin
            if (amp_cur < amp_r)      amp_cur <= amp_cur + 8'd1;
            else if (amp_cur > amp_r) amp_cur <= amp_cur - 8'd1;
        end
    end
`else
    assign amp_use = amp_r;
`endif

    // NOTE: every variable gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        sample_nxt = 16'd0;
        pcnt_nxt   = pcnt;
        mag        = {3'b000, amp_use, 5'b00000};
        if (per_r != 8'd0) begin
            if (pcnt == 8'd0) begin
                sample_nxt = {1'b0, amp_use, 7'b0000000};
                pcnt_nxt   = per_r - 8'd1;
            end else begin
                pcnt_nxt = pcnt - 8'd1;
            end
        end else begin
            sample_nxt = lfsr[0] ? mag : -mag;
        end
    end

    always_comb begin
        state_nxt = state;
        start_nxt = 1'b0;
        case (state)
            IDLE: if (bus.sample_tick) state_nxt = WAIT;
            WAIT: if (bus.filt_done) begin
                state_nxt = RUN;
                start_nxt = 1'b1;
            end
            // done is still high from the previous run until holdoff expires
            RUN:  if (!start_r && hcnt == '0 && bus.filt_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments in clocked blocks, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state   <= IDLE;
            start_r <= 1'b0;
            hcnt    <= '0;
        end else begin
            state   <= state_nxt;
            start_r <= start_nxt;
            if (state == WAIT && bus.filt_done)
                hcnt <= HW'(HOLDOFF);
            else if (state == RUN && !start_r && hcnt != '0)
                hcnt <= hcnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            per_r     <= 8'd0;
            amp_r     <= 8'd0;
            pcnt      <= 8'd0;
            lfsr      <= LFSR_SEED;
            sig_r     <= 16'd0;
            overrun_r <= 1'b0;
        end else begin
            if (accept) begin
                sig_r <= sample_nxt;
                lfsr  <= {lfsr[15:0], lfsr[16] ^ lfsr[13]};
            end
            // Leaving noise mode restarts the pitch phase so the first voiced sample is a pulse.
            if (bus.param_load && per_r == 8'd0 && bus.period != 8'd0)
                pcnt <= 8'd0;
            else if (accept)
                pcnt <= pcnt_nxt;
            if (bus.param_load) begin
                per_r <= bus.period;
                amp_r <= bus.amplitude;
            end
            if (tick_drop)
                overrun_r <= 1'b1;
            else if (bus.param_load)
                overrun_r <= 1'b0;
        end
    end

    assign bus.sig_out    = sig_r;
    assign bus.filt_start = start_r;
    assign bus.busy       = (state != IDLE);
    assign bus.overrun    = overrun_r;
endmodule

// File: tb/tb_excitation_source.sv
// Self-checking bench for excitation_source: directed scenarios plus randomized traffic
// compared against a sample-level reference model and a simple filter start/done model.
module tb_excitation_source;
    localparam logic [16:0] SEED = 17'h00001;

    logic clk    = 1'b0;
    logic rst_an = 1'b0;
    always #5 clk = ~clk;

    excitation_source_if bus ();

    excitation_source #(
        .LFSR_SEED(SEED),
        .HOLDOFF  (2)
    ) dut (
        .clk   (clk),
        .rst_an(rst_an),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int busy_len = 0;

    // Reference model state: latched frame, ticks left until the next pulse, noise register.
    int          per_m, amp_m, amp_cur_m, remain_m;
    logic [16:0] lfsr_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [16:0] lfsr_next(input logic [16:0] s);
        int v, fb;
        v  = int'(s);
        fb = ((v >> 16) ^ (v >> 13)) & 1;
        return 17'(((v * 2) + fb) % 131072);
    endfunction

    task automatic model_reset();
        per_m = 0; amp_m = 0; amp_cur_m = 0; remain_m = 0; lfsr_m = SEED;
    endtask

    task automatic model_load(input logic [7:0] p, input logic [7:0] a);
        if (per_m == 0 && p != 0) remain_m = 0;
        per_m = int'(p);
        amp_m = int'(a);
    endtask

    function automatic logic [15:0] model_tick();
        int a, s;
`ifdef EXCITATION_AMP_SMOOTH_EN
        a = amp_cur_m;
`else
        a = amp_m;
`endif
        if (per_m != 0) begin
            if (remain_m == 0) begin
                s = a * 128;
                remain_m = per_m - 1;
            end else begin
                s = 0;
                remain_m = remain_m - 1;
            end
        end else begin
            s = lfsr_m[0] ? a * 32 : -(a * 32);
        end
        lfsr_m = lfsr_next(lfsr_m);
`ifdef EXCITATION_AMP_SMOOTH_EN
        if (amp_cur_m < amp_m) amp_cur_m++;
        else if (amp_cur_m > amp_m) amp_cur_m--;
`endif
        return 16'(s);
    endfunction

    // Filter model: done stays high one cycle after it samples start, then low busy_len cycles.
    initial begin
        int n;
        forever begin
            @(posedge clk); #1;
            if (bus.filt_start && busy_len > 0) begin
                n = busy_len;
                repeat (2) @(posedge clk);
                #1 bus.filt_done = 1'b0;
                repeat (n) @(posedge clk);
                #1 bus.filt_done = 1'b1;
            end
        end
    end

    task automatic load(input logic [7:0] p, input logic [7:0] a);
        model_load(p, a);
        bus.period     = p;
        bus.amplitude  = a;
        bus.param_load = 1'b1;
        @(negedge clk);
        bus.param_load = 1'b0;
    endtask

    // Drives one tick from idle; returns at the negedge where filt_start should be high.
    task automatic issue_tick(input string tag, input bit do_load, input logic [7:0] p,
                              input logic [7:0] a, output logic [15:0] exp);
        exp = model_tick();
        if (do_load) model_load(p, a);
        bus.sample_tick = 1'b1;
        if (do_load) begin
            bus.period     = p;
            bus.amplitude  = a;
            bus.param_load = 1'b1;
        end
        @(negedge clk);
        bus.sample_tick = 1'b0;
        bus.param_load  = 1'b0;
        check({tag, ":sig"}, 32'(bus.sig_out), 32'(exp));
        check({tag, ":busy"}, 32'(bus.busy), 32'd1);
        check({tag, ":start_early"}, 32'(bus.filt_start), 32'd0);
        @(negedge clk);
        check({tag, ":start"}, 32'(bus.filt_start), 32'd1);
    endtask

    task automatic finish_tick(input string tag, input logic [15:0] exp);
        bit stable;
        stable = 1'b1;
        @(negedge clk);
        check({tag, ":start_one"}, 32'(bus.filt_start), 32'd0);
        for (int i = 0; i < 200 && bus.busy; i++) begin
            if (bus.sig_out !== exp) stable = 1'b0;
            @(negedge clk);
        end
        check({tag, ":stable"}, 32'(stable), 32'd1);
        check({tag, ":idle"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic full_tick(input string tag);
        logic [15:0] e;
        issue_tick(tag, 1'b0, 8'd0, 8'd0, e);
        finish_tick(tag, e);
    endtask

    initial begin
        logic [15:0] e;
        int          pulses, rise, idle, starts, r;
        bit          saw_low, stable;

        bus.sample_tick = 1'b0;
        bus.period      = 8'd0;
        bus.amplitude   = 8'd0;
        bus.param_load  = 1'b0;
        bus.filt_done   = 1'b1;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst:sig", 32'(bus.sig_out), 32'd0);
        check("rst:start", 32'(bus.filt_start), 32'd0);
        check("rst:busy", 32'(bus.busy), 32'd0);
        check("rst:overrun", 32'(bus.overrun), 32'd0);
        rst_an = 1'b1;
        @(negedge clk);

        // Voiced pulse train
        load(8'd4, 8'h40);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            issue_tick($sformatf("voiced%0d", i), 1'b0, 8'd0, 8'd0, e);
            if (bus.sig_out == 16'h2000) pulses++;
            finish_tick($sformatf("voiced%0d", i), e);
        end
`ifndef EXCITATION_AMP_SMOOTH_EN
        check("voiced:pulses", 32'(pulses), 32'd3);
`endif

        // Noise
        load(8'd0, 8'h10);
        for (int i = 0; i < 64; i++) full_tick($sformatf("noise%0d", i));

        // Handshake holdoff with a slow filter
        busy_len = 40;
        issue_tick("hold", 1'b0, 8'd0, 8'd0, e);
        rise = -1; idle = -1; starts = 0; saw_low = 1'b0; stable = 1'b1;
        for (int i = 0; i < 120; i++) begin
            if (bus.filt_start) starts++;
            if (!bus.filt_done) saw_low = 1'b1;
            else if (saw_low && rise < 0) rise = i;
            if (!bus.busy) begin
                idle = i;
                break;
            end
            if (bus.sig_out !== e) stable = 1'b0;
            @(negedge clk);
        end
        busy_len = 0;
        check("hold:saw_low", 32'(saw_low), 32'd1);
        check("hold:late_rise", 32'(rise >= 40), 32'd1);
        check("hold:idle_after_rise", 32'(idle - rise), 32'd1);
        check("hold:stable", 32'(stable), 32'd1);
        check("hold:one_start", 32'(starts), 32'd1);

        // Overrun: a tick during RUN is dropped and flagged
        check("ovr:clear_before", 32'(bus.overrun), 32'd0);
        busy_len = 10;
        issue_tick("ovr", 1'b0, 8'd0, 8'd0, e);
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        check("ovr:set", 32'(bus.overrun), 32'd1);
        check("ovr:sig_held", 32'(bus.sig_out), 32'(e));
        finish_tick("ovr", e);
        busy_len = 0;
        full_tick("ovr_next");
        check("ovr:sticky", 32'(bus.overrun), 32'd1);
        load(8'd0, 8'h10);
        check("ovr:cleared", 32'(bus.overrun), 32'd0);

        // Mode switch noise -> voiced, full-scale amplitude
        full_tick("sw_noise0");
        full_tick("sw_noise1");
        load(8'd3, 8'hFF);
        issue_tick("sw_pulse", 1'b0, 8'd0, 8'd0, e);
`ifndef EXCITATION_AMP_SMOOTH_EN
        check("sw:full_scale", 32'(bus.sig_out), 32'h7F80);
`endif
        finish_tick("sw_pulse", e);
        for (int i = 0; i < 4; i++) full_tick($sformatf("sw_v%0d", i));

        // Tick and load in the same cycle: sample uses the old frame
        issue_tick("tl", 1'b1, 8'd0, 8'h20, e);
        finish_tick("tl", e);
        full_tick("tl_after");

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            busy_len = $urandom_range(0, 6);
            r = $urandom_range(0, 3);
            if (r == 0) load(8'($urandom_range(0, 5)), 8'($urandom));
            if (r == 1) begin
                issue_tick($sformatf("rnd%0d", i), 1'b1, 8'($urandom_range(0, 5)), 8'($urandom), e);
                finish_tick($sformatf("rnd%0d", i), e);
            end else begin
                full_tick($sformatf("rnd%0d", i));
            end
        end
        busy_len = 0;
        repeat (10) @(negedge clk);

        // Reset in the middle of a run
        load(8'd0, 8'h10);
        busy_len = 40;
        issue_tick("rstrun", 1'b0, 8'd0, 8'd0, e);
        rst_an = 1'b0;
        #1;
        check("rstrun:sig", 32'(bus.sig_out), 32'd0);
        check("rstrun:start", 32'(bus.filt_start), 32'd0);
        check("rstrun:busy", 32'(bus.busy), 32'd0);
        check("rstrun:overrun", 32'(bus.overrun), 32'd0);
        model_reset();
        busy_len = 0;
        @(negedge clk);
        rst_an = 1'b1;
        repeat (60) @(negedge clk);
        load(8'd0, 8'h10);
        issue_tick("post_rst0", 1'b0, 8'd0, 8'd0, e);
`ifndef EXCITATION_AMP_SMOOTH_EN
        check("post_rst:first", 32'(bus.sig_out), 32'h0200);
`endif
        finish_tick("post_rst0", e);
        for (int i = 1; i < 8; i++) full_tick($sformatf("post_rst%0d", i));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/excitation_source.md
Name: excitation_source

Overview:
- Upstream excitation generator for the 12th-order all-pole filter.
- Once per sample tick, produces one signed 16-bit excitation sample:
  - periodic pulse train when voiced;
  - LFSR noise when unvoiced.
- Scales the sample by the frame amplitude.
- Hands the sample to the filter over its start/done handshake and holds it stable until the filter finishes.

Parameters:
- LFSR_SEED, 17'h00001, LFSR reset/seed value; must be non-zero.
- HOLDOFF, 2, cycles after filt_start during which filt_done is ignored.

Ports:
- clk  in  1  system clock
- rst_an  in  1  asynchronous reset, active-low
- sample_tick  in  1  one-cycle sample-rate strobe
- period  in  8  pitch period in samples; 0 = unvoiced (noise)
- amplitude  in  8  unsigned excitation amplitude
- param_load  in  1  one-cycle pulse; latches period/amplitude and clears overrun
- sig_out  out  16  signed excitation sample, to filter sig_in
- filt_start  out  1  one-cycle start pulse to filter
- filt_done  in  1  filter done/idle level
- busy  out  1  1 whenever FSM is not IDLE
- overrun  out  1  sticky: a tick arrived while busy

Behaviour:
- Reset values: sig_out=0, filt_start=0, busy=0, overrun=0. Internally: per_r=0, amp_r=0, pcnt=0, lfsr=LFSR_SEED, FSM=IDLE.
- param_load:
  - per_r<=period, amp_r<=amplitude, overrun<=0.
  - If per_r==0 and period!=0 (noise->voiced), also pcnt<=0, so the next tick emits a pulse. Otherwise pcnt is untouched.
  - Allowed in any state; new values apply from the next sample computed.
- LFSR: 17-bit Fibonacci, taps x^17+x^14+1. Shifts once per accepted tick in both modes. Next bit = lfsr[16]^lfsr[13], shifted into bit 0.
- Sample computation, on an accepted tick in IDLE, registered to sig_out at that edge:
  - Voiced, per_r!=0:
    - if pcnt==0: sig_out={1'b0,amp_r,7'b0} (amp*128, max 32640) and pcnt<=per_r-1;
    - else: sig_out=0 and pcnt<=pcnt-1.
    - period=1 gives a pulse on every sample.
  - Unvoiced, per_r==0: magnitude m={3'b0,amp_r,5'b0} (amp*32); sig_out = lfsr[0] ? +m : -m (two's complement).
- FSM:
  - IDLE (busy=0): on sample_tick, compute sample and go to WAIT.
  - WAIT: if filt_done==1, drive filt_start=1 for exactly one cycle and go to RUN. Otherwise stay.
  - RUN: ignore filt_done for HOLDOFF cycles after the filt_start cycle, because the filter's done stays high one cycle after it samples start. After that, filt_done==1 returns to IDLE.
  - Total: tick to filt_start is 2 cycles when the filter is already idle.
- sig_out holds constant from computation until the FSM returns to IDLE.
- sample_tick while busy=1:
  - overrun<=1, sticky;
  - tick dropped; pcnt and LFSR not advanced; sig_out unchanged.
- sample_tick and param_load in the same cycle in IDLE: the sample uses the old latched values; the new values are latched at the same edge.
- Reset mid-operation: everything returns to reset values immediately; filt_start deasserts asynchronously.

Optional Feature:
- Macro: EXCITATION_AMP_SMOOTH_EN.
- When defined:
  - The amplitude used for computation is amp_cur, not amp_r.
  - On each accepted tick, amp_cur steps by 1 toward amp_r, or equals amp_r if already there. The step is applied after the sample is computed with the current amp_cur.
  - amp_cur resets to 0.
- When not defined: amp_cur does not exist; amp_r is used directly, so amplitude jumps take effect on the next sample.

Test Plan:
- Voiced pulse train: param_load period=4, amplitude=8'h40; 12 ticks with filter model idle -> sig_out=16'h2000 on ticks 1, 5, 9; 0 on all others; one filt_start per tick, 2 cycles after the tick.
- Noise: period=0, amplitude=8'h10, seed 1 -> sig_out is ±16'h0200 with sign following lfsr[0] against a reference LFSR model; sequence repeats only after 2^17-1 ticks (check first 64 values).
- Handshake holdoff: filter model holds filt_done=1 for 1 cycle after start, then low 40 cycles, then high -> no return to IDLE before the done rising edge; sig_out stable throughout; busy=1 throughout.
- Overrun: tick while in RUN -> overrun=1, pcnt/LFSR frozen (next sample equals the expected undropped-next value); param_load -> overrun=0.
- Mode switch: noise to period=3 mid-stream -> first tick after load emits pulse 16'h(amp*128); amplitude=8'hFF gives 16'h7F80, no overflow.
- Reset mid-RUN: assert rst_an low during RUN -> sig_out=0, filt_start=0, busy=0 immediately; the first post-reset noise sample matches the seed sequence.
